// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode/register/immediate fields into 16-bit instruction words,
// rejects illegal requests and buffers legal words in a first-word-fall-through FIFO.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [2:0]               in_rd,
    input  logic [2:0]               in_rs1,
    input  logic [2:0]               in_rs2,
    input  logic [15:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_instr,
    output logic                     err_valid,
    output logic [1:0]               err_code,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   mem_q [DEPTH];
    logic          en_q;
    logic          err_valid_q;
    logic [1:0]    err_code_q;
    logic [7:0]    err_count_q;
    logic          i_type, bad_op, bad_imm, accept, push, pop;
    logic [15:0]   word;

    always_comb begin
        i_type  = (in_op == 3'b001) || (in_op == 3'b010);
        bad_op  = in_op[2];
        // immediate fits in 7-bit two's complement when bits [15:6] are all equal
        bad_imm = i_type && !((&in_imm[15:6]) || (~|in_imm[15:6]));
        word    = i_type ? {in_op, in_rd, in_rs1, in_imm[6:0]}
                         : {in_op, in_rd, in_rs1, in_rs2, 4'b0000};
        in_ready  = en_q && (count_q != (AW+1)'(DEPTH));
        out_valid = (count_q != '0);
        out_instr = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
        accept    = in_valid && in_ready;
        push      = accept && !bad_op && !bad_imm;
        pop       = out_valid && out_ready;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    assign fifo_count = count_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            en_q        <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_count_q <= 8'd0;
        end else begin
            en_q        <= 1'b1;
            count_q     <= count_d;
            err_valid_q <= accept && (bad_op || bad_imm);
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (accept && (bad_op || bad_imm)) begin
                err_code_q <= bad_op ? 2'b01 : 2'b10;
                if (err_count_q != 8'hFF)
                    err_count_q <= err_count_q + 8'd1;
            end
        end
    end
endmodule
